ctrl_pipeline: RTL and testbench

Carries the decoded control bundle from the ID stage through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core. It is the consumer side of the opcode decoder: it turns the per-opcode control word into per-stage control outputs. It detects load-use hazards, squashes wrong-path instructions on taken branches and jumps, and generates EX-stage forwarding selects. It sits between the decoder/register file (ID) and the datapath muxes of EX/MEM/WB.

---
 rtl/ctrl_pkg.sv | 52 +++++
 rtl/ctrl_pipeline_hazard.sv | 42 ++++
 rtl/ctrl_pipeline.sv | 126 ++++++++++++
 tb/tb_ctrl_pipeline.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the MIPS control pipeline.
package ctrl_pkg;

  // Decoder bundle, MSB first, in the order the decoder packs it.
  typedef struct packed {
    logic       regdst;
    logic       regwrite;
    logic       alusrc;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       jump;
    logic [3:0] aluop;
  } ctrl_t;

  // ID/EX control: the bundle minus Jump, which is fully consumed in ID.
  typedef struct packed {
    logic       regdst;
    logic       regwrite;
    logic       alusrc;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic [3:0] aluop;
  } ex_ctrl_t;

  localparam logic [3:0] ALU_BEQ   = 4'b0001;
  localparam logic [3:0] ALU_RTYPE = 4'b0010;
  localparam logic [3:0] ALU_BNE   = 4'b0011;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_AND   = 4'b0101;
  localparam logic [3:0] ALU_ADDU  = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  localparam ctrl_t    BUBBLE    = '0;
  localparam ex_ctrl_t EX_BUBBLE = '0;

  function automatic ex_ctrl_t to_ex(input ctrl_t c);
    return ex_ctrl_t'({c.regdst, c.regwrite, c.alusrc, c.branch,
                       c.memread, c.memwrite, c.memtoreg, c.aluop});
  endfunction

endpackage

// File: rtl/ctrl_pipeline_hazard.sv
// Combinational load-use detection and EX operand forwarding selects.
module hazard_unit
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_wreg,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_wreg,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_wreg,
  output logic             load_use,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  // MEM result is younger than WB result, so it wins when both match.
  function automatic fwd_e pick(input logic [REG_W-1:0] src,
                                input logic mrw, input logic [REG_W-1:0] mw,
                                input logic wrw, input logic [REG_W-1:0] ww);
    if (mrw && (mw != '0) && (mw == src))
      return FWD_MEM;
    else if (wrw && (ww != '0) && (ww == src))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

  // rt is compared even for I-type consumers: conservative by design.
  always_comb begin
    load_use = ex_memread && (ex_wreg != '0) &&
               ((ex_wreg == id_rs) || (ex_wreg == id_rt));
    fwd_a    = pick(ex_rs, mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
    fwd_b    = pick(ex_rt, mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers with hazard and squash control.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [11:0]      id_ctrl,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             flush_ifid,
  output logic             ex_alusrc,
  output logic             ex_branch,
  output logic [3:0]       ex_aluop,
  output logic [REG_W-1:0] ex_wreg,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic [REG_W-1:0] wb_wreg
);

  ctrl_t            id_bundle;
  ex_ctrl_t         idex_ctrl;
  logic [REG_W-1:0] idex_rs, idex_rt, idex_rd;

  logic             exmem_regwrite, exmem_memread, exmem_memwrite, exmem_memtoreg;
  logic [REG_W-1:0] exmem_wreg;

  logic             memwb_regwrite, memwb_memtoreg;
  logic [REG_W-1:0] memwb_wreg;

  logic             load_use, squash;

  assign id_bundle = ctrl_t'(id_ctrl);
  assign ex_wreg   = idex_ctrl.regdst ? idex_rd : idex_rt;

  hazard_unit #(.REG_W(REG_W)) u_hazard (
    .ex_memread   (idex_ctrl.memread),
    .ex_wreg      (ex_wreg),
    .ex_rs        (idex_rs),
    .ex_rt        (idex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .mem_regwrite (exmem_regwrite),
    .mem_wreg     (exmem_wreg),
    .wb_regwrite  (memwb_regwrite),
    .wb_wreg      (memwb_wreg),
    .load_use     (load_use),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  // A taken branch overrides the load-use stall; both insert an EX bubble.
  always_comb begin
    stall      = load_use && !ex_branch_taken;
    flush_ifid = ex_branch_taken || (id_bundle.jump && !load_use);
    squash     = load_use || ex_branch_taken;
  end

  // ID/EX: capture the decoded instruction, or a bubble on stall/branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ctrl <= EX_BUBBLE;
      idex_rs   <= '0;
      idex_rt   <= '0;
      idex_rd   <= '0;
    end else if (squash) begin
      idex_ctrl <= EX_BUBBLE;
      idex_rs   <= '0;
      idex_rt   <= '0;
      idex_rd   <= '0;
    end else begin
      idex_ctrl <= to_ex(id_bundle);
      idex_rs   <= id_rs;
      idex_rt   <= id_rt;
      idex_rd   <= id_rd;
    end
  end

  // EX/MEM: always advances, carrying the resolved destination register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_regwrite <= 1'b0;
      exmem_memread  <= 1'b0;
      exmem_memwrite <= 1'b0;
      exmem_memtoreg <= 1'b0;
      exmem_wreg     <= '0;
    end else begin
      exmem_regwrite <= idex_ctrl.regwrite;
      exmem_memread  <= idex_ctrl.memread;
      exmem_memwrite <= idex_ctrl.memwrite;
      exmem_memtoreg <= idex_ctrl.memtoreg;
      exmem_wreg     <= ex_wreg;
    end
  end

  // MEM/WB: always advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_regwrite <= 1'b0;
      memwb_memtoreg <= 1'b0;
      memwb_wreg     <= '0;
    end else begin
      memwb_regwrite <= exmem_regwrite;
      memwb_memtoreg <= exmem_memtoreg;
      memwb_wreg     <= exmem_wreg;
    end
  end

  assign ex_alusrc    = idex_ctrl.alusrc;
  assign ex_branch    = idex_ctrl.branch;
  assign ex_aluop     = idex_ctrl.aluop;
  assign mem_memread  = exmem_memread;
  assign mem_memwrite = exmem_memwrite;
  assign wb_regwrite  = memwb_regwrite;
  assign wb_memtoreg  = memwb_memtoreg;
  assign wb_wreg      = memwb_wreg;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: directed scenarios plus randomized
// instruction streams checked against an instruction-level pipeline model.
module tb_ctrl_pipeline;
  import ctrl_pkg::*;

  localparam logic [11:0] C_RTYPE = 12'b110000000010;
  localparam logic [11:0] C_LW    = 12'b011010100100;
  localparam logic [11:0] C_SW    = 12'b001001000100;
  localparam logic [11:0] C_BEQ   = 12'b000100000001;
  localparam logic [11:0] C_J     = 12'b000000010000;
  localparam logic [11:0] C_ADDI  = 12'b011000000100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] id_ctrl = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        ex_branch_taken = 1'b0;
  logic        stall, flush_ifid, ex_alusrc, ex_branch;
  logic [3:0]  ex_aluop;
  logic [4:0]  ex_wreg, wb_wreg;
  logic [1:0]  fwd_a, fwd_b;
  logic        mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg;

  int vectors = 0;
  int miscompares = 0;

  ctrl_pipeline #(.REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .ex_branch_taken(ex_branch_taken), .stall(stall),
    .flush_ifid(flush_ifid), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
    .ex_aluop(ex_aluop), .ex_wreg(ex_wreg), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_wreg(wb_wreg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  logic [5:0]  act_comb;
  logic [19:0] act_regs;
  assign act_comb = {stall, flush_ifid, fwd_a, fwd_b};
  assign act_regs = {ex_alusrc, ex_branch, ex_aluop, ex_wreg, mem_memread,
                     mem_memwrite, wb_regwrite, wb_memtoreg, wb_wreg};

  // Model: one whole instruction per stage slot; a bubble is all-zero.
  typedef struct packed {
    logic [11:0] c;
    logic [4:0]  rs, rt, rd;
  } ins_t;

  ins_t m_ex = '0, m_mem = '0, m_wb = '0;

  function automatic logic [4:0] dst(input ins_t i);
    return i.c[11] ? i.rd : i.rt;
  endfunction

  function automatic logic writes(input ins_t i, input logic [4:0] r);
    return i.c[10] && (dst(i) != 0) && (dst(i) == r);
  endfunction

  function automatic logic exp_lu();
    return m_ex.c[7] && (dst(m_ex) != 0) &&
           ((dst(m_ex) == id_rs) || (dst(m_ex) == id_rt));
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] r);
    if (writes(m_mem, r)) return 2'b10;
    if (writes(m_wb, r))  return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [5:0] exp_comb();
    logic lu;
    lu = exp_lu();
    return {lu && !ex_branch_taken, ex_branch_taken || (id_ctrl[4] && !lu),
            exp_fwd(m_ex.rs), exp_fwd(m_ex.rt)};
  endfunction

  function automatic logic [19:0] exp_regs();
    logic [3:0] op;
    op = m_ex.c[3:0];
    return {m_ex.c[9], m_ex.c[8], op, dst(m_ex), m_mem.c[7], m_mem.c[6],
            m_wb.c[10], m_wb.c[5], dst(m_wb)};
  endfunction

  // Drive ID inputs (called just after a falling edge) and let logic settle.
  task automatic apply(input logic [11:0] c, input logic [4:0] s, t, d,
                       input logic bt);
    id_ctrl = c; id_rs = s; id_rt = t; id_rd = d; ex_branch_taken = bt;
    #1;
  endtask

  // Advance one clock, moving the model one stage, and return after the falling edge.
  task automatic tick();
    logic hold;
    hold = exp_lu() || ex_branch_taken;
    @(posedge clk);
    m_wb  = m_mem;
    m_mem = m_ex;
    if (hold) m_ex = '0;
    else      m_ex = {id_ctrl, id_rs, id_rt, id_rd};
    @(negedge clk);
  endtask

  task automatic drain();
    apply('0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    apply(C_RTYPE, 1, 2, 3, 0);
    vectors++;
    if ({act_comb, act_regs} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", {act_comb, act_regs});
    end
    @(negedge clk);
    vectors++;
    if (act_regs !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_held_edge: got %h expected 0", act_regs);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (ex_aluop !== ALU_RTYPE) begin
      miscompares++;
      $display("FAIL reset_first_edge_aluop: got %b expected %b", ex_aluop, ALU_RTYPE);
    end
    tick();
    tick();
    vectors++;
    if (wb_regwrite !== 1'b1 || wb_wreg !== 5'd3) begin
      miscompares++;
      $display("FAIL reset_wb_latency: got rw=%b wreg=%0d expected rw=1 wreg=3",
               wb_regwrite, wb_wreg);
    end
  endtask

  task automatic test_load_use();
    drain();
    apply(C_LW, 1, 8, 0, 0);
    tick();
    apply(C_RTYPE, 8, 2, 10, 0);
    vectors++;
    if (stall !== 1'b1 || flush_ifid !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_stall: got stall=%b flush=%b expected stall=1 flush=0", stall, flush_ifid);
    end
    tick();
    apply(C_RTYPE, 8, 2, 10, 0);
    vectors++;
    if ({ex_alusrc, ex_branch, ex_aluop, ex_wreg} !== 11'd0) begin
      miscompares++;
      $display("FAIL lu_bubble: got %h expected 0", {ex_alusrc, ex_branch, ex_aluop, ex_wreg});
    end
    vectors++;
    if (stall !== 1'b0 || mem_memread !== 1'b1) begin
      miscompares++;
      $display("FAIL lu_one_cycle: got stall=%b memread=%b expected stall=0 memread=1",
               stall, mem_memread);
    end
    tick();
    apply('0, 0, 0, 0, 0);
    vectors++;
    if (ex_aluop !== ALU_RTYPE || ex_wreg !== 5'd10) begin
      miscompares++;
      $display("FAIL lu_add_late: got aluop=%b wreg=%0d expected aluop=0010 wreg=10",
               ex_aluop, ex_wreg);
    end
    vectors++;
    if (fwd_a !== 2'b01) begin
      miscompares++;
      $display("FAIL lu_fwd_from_wb: got %b expected 01", fwd_a);
    end
  endtask

  task automatic test_forward();
    drain();
    apply(C_RTYPE, 1, 2, 9, 0); tick();
    apply(C_RTYPE, 3, 4, 9, 0); tick();
    apply(C_RTYPE, 9, 5, 6, 0); tick();
    apply('0, 0, 0, 0, 0);
    vectors++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
      miscompares++;
      $display("FAIL fwd_mem_priority: got a=%b b=%b expected a=10 b=00", fwd_a, fwd_b);
    end
    apply(C_RTYPE, 1, 2, 9, 0); tick();
    apply(C_RTYPE, 1, 2, 7, 0); tick();
    apply(C_RTYPE, 9, 9, 6, 0); tick();
    apply('0, 0, 0, 0, 0);
    vectors++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
      miscompares++;
      $display("FAIL fwd_wb_only: got a=%b b=%b expected a=01 b=01", fwd_a, fwd_b);
    end
    apply(C_RTYPE, 1, 2, 0, 0); tick();
    apply(C_RTYPE, 1, 2, 0, 0); tick();
    apply(C_RTYPE, 0, 0, 6, 0); tick();
    apply('0, 0, 0, 0, 0);
    vectors++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      miscompares++;
      $display("FAIL fwd_zero_reg: got a=%b b=%b expected a=00 b=00", fwd_a, fwd_b);
    end
  endtask

  task automatic test_branch();
    drain();
    apply(C_LW, 1, 8, 0, 0); tick();
    apply(C_RTYPE, 8, 2, 10, 1);
    vectors++;
    if (stall !== 1'b0 || flush_ifid !== 1'b1) begin
      miscompares++;
      $display("FAIL br_over_stall: got stall=%b flush=%b expected stall=0 flush=1",
               stall, flush_ifid);
    end
    tick();
    apply('0, 0, 0, 0, 0);
    vectors++;
    if ({ex_alusrc, ex_branch, ex_aluop, ex_wreg} !== 11'd0) begin
      miscompares++;
      $display("FAIL br_bubble: got %h expected 0", {ex_alusrc, ex_branch, ex_aluop, ex_wreg});
    end
    apply(C_BEQ, 1, 2, 0, 0); tick();
    apply(C_J, 0, 0, 0, 1);
    vectors++;
    if (flush_ifid !== 1'b1 || ex_branch !== 1'b1 || ex_aluop !== ALU_BEQ) begin
      miscompares++;
      $display("FAIL br_beq_in_ex: got flush=%b br=%b op=%b expected flush=1 br=1 op=0001",
               flush_ifid, ex_branch, ex_aluop);
    end
    tick();
    apply('0, 0, 0, 0, 0);
    vectors++;
    if ({flush_ifid, ex_alusrc, ex_branch, ex_aluop, ex_wreg} !== 12'd0) begin
      miscompares++;
      $display("FAIL br_squash_jump: got %h expected 0",
               {flush_ifid, ex_alusrc, ex_branch, ex_aluop, ex_wreg});
    end
  endtask

  task automatic test_jump();
    drain();
    apply(C_J, 0, 0, 0, 0);
    vectors++;
    if (flush_ifid !== 1'b1 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL jump_flush: got flush=%b stall=%b expected flush=1 stall=0", flush_ifid, stall);
    end
    tick();
    apply('0, 0, 0, 0, 0);
    vectors++;
    if ({flush_ifid, ex_alusrc, ex_branch, ex_aluop, ex_wreg} !== 12'd0) begin
      miscompares++;
      $display("FAIL jump_in_ex: got %h expected 0",
               {flush_ifid, ex_alusrc, ex_branch, ex_aluop, ex_wreg});
    end
    tick();
    vectors++;
    if (mem_memwrite !== 1'b0 || mem_memread !== 1'b0) begin
      miscompares++;
      $display("FAIL jump_in_mem: got mw=%b mr=%b expected 0 0", mem_memwrite, mem_memread);
    end
  endtask

  task automatic test_nop();
    drain();
    apply(C_RTYPE, 1, 2, 3, 0); tick();
    for (int unsigned k = 0; k < 3; k++) begin
      apply('0, 3, 4, 5, 0);
      tick();
      if (k == 2) begin
        vectors++;
        if (wb_regwrite !== 1'b0) begin
          miscompares++;
          $display("FAIL nop_wb_regwrite cycle %0d: got %b expected 0", k, wb_regwrite);
        end
      end else begin
        vectors++;
        if (mem_memwrite !== 1'b0 || ex_aluop !== 4'b0000) begin
          miscompares++;
          $display("FAIL nop_propagate cycle %0d: got mw=%b op=%b expected 0 0000",
                   k, mem_memwrite, ex_aluop);
        end
      end
    end
  endtask

  task automatic test_random(input int unsigned cycles);
    logic [11:0] c;
    logic [4:0]  s, t, d;
    logic        bt;
    for (int unsigned n = 0; n < cycles; n++) begin
      case ($urandom_range(0, 7))
        0: c = C_RTYPE;
        1: c = C_LW;
        2: c = C_SW;
        3: c = C_BEQ;
        4: c = C_J;
        5: c = C_ADDI;
        6: c = '0;
        default: c = 12'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) begin
        s = 5'($urandom); t = 5'($urandom); d = 5'($urandom);
      end else begin
        s = 5'($urandom_range(0, 3)); t = 5'($urandom_range(0, 3)); d = 5'($urandom_range(0, 3));
      end
      bt = m_ex.c[8] ? 1'($urandom_range(0, 1)) : 1'b0;
      apply(c, s, t, d, bt);
      vectors++;
      if (act_comb !== exp_comb()) begin
        miscompares++;
        $display("FAIL rand_comb cycle %0d: got %b expected %b", n, act_comb, exp_comb());
      end
      vectors++;
      if (act_regs !== exp_regs()) begin
        miscompares++;
        $display("FAIL rand_regs cycle %0d: got %h expected %h", n, act_regs, exp_regs());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    apply(C_LW, 1, 8, 0, 0); tick();
    apply(C_RTYPE, 2, 3, 4, 0); tick();
    apply(C_RTYPE, 5, 6, 7, 0); tick();
    apply('0, 1, 2, 3, 0);
    #2;
    rst_n = 1'b0;
    m_ex = '0; m_mem = '0; m_wb = '0;
    #1;
    vectors++;
    if ({act_comb, act_regs} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got %h expected 0", {act_comb, act_regs});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_jump();
    test_nop();
    test_random(400);
    test_reset_mid();
    test_random(100);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
